sdr_wb_pattern_gen: RTL

SDR_WB_PATTERN_GEN -- requirements
Module: sdr_wb_pattern_gen

---
 rtl/sdr_wb_pattern_gen.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdr_wb_pattern_gen.sv
// -----------------------------------------------------------------------------
// sdr_wb_pattern_gen
//
// Wishbone memory test master. On a start pulse it writes cfg_len pattern words
// starting at cfg_base_addr (word aligned), then reads the same words back and
// compares each against the regenerated pattern. Mismatches are counted, and
// the byte address of the first mismatch is captured. Every access is a single
// classic cycle followed by one idle (gap) cycle.
//
// Build option:
//   SDR_PGEN_LFSR_EN  defined   : P(0)=seed (zero replaced by 1), P(i+1) is a
//                                 32-bit right-shift Galois LFSR step of P(i),
//                                 polynomial 0x80200003 (intended for dw=32).
//                     undefined : P(i) = seed + i, modulo 2^dw.
//
// Parameters:
//   APP_AW  Wishbone byte-address width
//   dw      Wishbone data width
//
// Ports:
//   wb_clk_i, wb_rst_i     clock (rising edge), async active-high reset
//   start, abort           one-cycle launch / stop requests
//   cfg_base_addr          start byte address, bits [1:0] ignored
//   cfg_len                number of words (0 = finish immediately, pass)
//   cfg_seed               pattern seed
//   wb_*                   Wishbone master (cyc/stb/we/addr/dat/sel/cti, ack/dat_i)
//   busy                   a test is running (write/read phases and gaps)
//   done                   one-cycle completion pulse
//   pass                   last test had no mismatch and was not aborted
//   err_cnt                saturating mismatch count
//   first_err_addr         byte address of the first mismatch
// -----------------------------------------------------------------------------
module sdr_wb_pattern_gen #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned dw     = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // Control
  input  logic              start,
  input  logic              abort,
  input  logic [APP_AW-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_len,
  input  logic [dw-1:0]     cfg_seed,
  // Wishbone master
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  // Status
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [APP_AW-1:0] first_err_addr
);

  localparam logic [APP_AW-1:0] AddrStep  = APP_AW'(4);
  localparam logic [APP_AW-1:0] AlignMask = ~APP_AW'(3);
  localparam logic [dw-1:0]     PatOne    = dw'(1);
`ifdef SDR_PGEN_LFSR_EN
  localparam logic [dw-1:0]     LfsrPoly  = dw'(32'h8020_0003);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWgap,
    StRead,
    StRgap,
    StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [APP_AW-1:0]   base_q, base_d;
  logic [APP_AW-1:0]   addr_q, addr_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         idx_q, idx_d;
  logic [dw-1:0]       seed_q, seed_d;
  logic [dw-1:0]       pat_q, pat_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [APP_AW-1:0]   first_err_q, first_err_d;
  logic                pass_q, pass_d;
  logic                abort_q, abort_d;
  logic                bus_active;

  // First pattern word for a given seed.
  function automatic logic [dw-1:0] pat_seed(input logic [dw-1:0] s);
`ifdef SDR_PGEN_LFSR_EN
    // An all-zero state would lock the LFSR.
    return (s == '0) ? PatOne : s;
`else
    return s;
`endif
  endfunction

  // Pattern word i+1 from word i.
  function automatic logic [dw-1:0] pat_next(input logic [dw-1:0] s);
`ifdef SDR_PGEN_LFSR_EN
    return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
`else
    return s + PatOne;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    pat_d       = pat_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    abort_d     = abort_q;

    case (state_q)
      StIdle: begin
        // abort is deliberately ignored here.
        if (start) begin
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          abort_d     = 1'b0;
          if (cfg_len != 16'd0) begin
            base_d  = cfg_base_addr & AlignMask;
            addr_d  = cfg_base_addr & AlignMask;
            len_d   = cfg_len;
            idx_d   = '0;
            seed_d  = cfg_seed;
            pat_d   = pat_seed(cfg_seed);
            state_d = StWrite;
          end else begin
            state_d = StFinish;
          end
        end
      end

      StWrite: begin
        // An abort while waiting is remembered; the access still completes.
        if (abort) begin
          abort_d = 1'b1;
        end
        if (wb_ack_i) begin
          idx_d   = idx_q + 16'd1;
          addr_d  = addr_q + AddrStep;
          pat_d   = pat_next(pat_q);
          state_d = abort_d ? StFinish : StWgap;
        end
      end

      StWgap: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = StFinish;
        end else if (idx_q == len_q) begin
          // All words written: restart at word 0 with a re-seeded pattern.
          idx_d   = '0;
          addr_d  = base_q;
          pat_d   = pat_seed(seed_q);
          state_d = StRead;
        end else begin
          state_d = StWrite;
        end
      end

      StRead: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        if (wb_ack_i) begin
          if (wb_dat_i != pat_q) begin
            if (err_cnt_q == 16'd0) begin
              first_err_d = addr_q;
            end
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
          idx_d  = idx_q + 16'd1;
          addr_d = addr_q + AddrStep;
          pat_d  = pat_next(pat_q);
          if (abort_d || (idx_q + 16'd1 == len_q)) begin
            state_d = StFinish;
          end else begin
            state_d = StRgap;
          end
        end
      end

      StRgap: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = StFinish;
        end else begin
          state_d = StRead;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Resolve pass on entry to FINISH so it is valid alongside the done pulse,
    // including a mismatch or abort that lands on the final ack.
    if ((state_d == StFinish) && (state_q != StFinish)) begin
      pass_d = (err_cnt_d == 16'd0) && !abort_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      seed_q      <= '0;
      pat_q       <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      pat_q       <= pat_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      abort_q     <= abort_d;
    end
  end

  // Bus outputs decode straight from the state register, so an asynchronous
  // reset drops cyc/stb in the same cycle.
  assign bus_active     = (state_q == StWrite) || (state_q == StRead);
  assign wb_cyc_o       = bus_active;
  assign wb_stb_o       = bus_active;
  assign wb_we_o        = (state_q == StWrite);
  assign wb_addr_o      = bus_active ? addr_q : '0;
  assign wb_dat_o       = (state_q == StWrite) ? pat_q : '0;
  assign wb_sel_o       = bus_active ? '1 : '0;
  assign wb_cti_o       = bus_active ? 3'b111 : 3'b000;

  assign busy           = (state_q == StWrite) || (state_q == StWgap) ||
                          (state_q == StRead)  || (state_q == StRgap);
  assign done           = (state_q == StFinish);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule
